// File: rtl/main_mem_pkg.sv
// Shared types and constants for the main-memory responder.
package main_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int unsigned LAT_CNT_W = 4;

endpackage

// File: rtl/main_mem_array.sv
// Single-port word RAM: synchronous write, synchronous registered read.
// Contents are not reset; only the read register clears on iRST_n.
module main_mem_array #(
    parameter int DEPTH_W = 10,
    parameter int DATA_W  = 32
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              we,
    input  logic              re,
    input  logic [DEPTH_W-1:0] addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_W];

    always_ff @(posedge iCLK) begin
        if (we) mem[addr] <= wdata;
    end

    // Read register holds its value until the next read completes.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n)  rdata <= '0;
        else if (re)  rdata <= mem[addr];
    end

endmodule

// File: rtl/main_mem_controller.sv
// Fixed-latency main-memory responder for the cache request interface.
// Optional `MAIN_MEM_STATS_EN adds rd_count/wr_count completion counters.
module main_mem_controller
    import main_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 10,
    parameter int LATENCY = 4
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [ADDR_W-1:0] cache2mem_addr,
    input  logic [DATA_W-1:0] cache2mem_data,
    input  logic              cache2mem_MemWrite,
    input  logic              cache2mem_MemRead,
    output logic [DATA_W-1:0] mem2cache_data,
    output logic              mem2cache_ready,
    output logic              mem_busy
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    state_t                state, next_state;
    logic [LAT_CNT_W-1:0]  cnt, cnt_d;
    logic [DEPTH_W-1:0]    idx_q;
    logic [DATA_W-1:0]     wdata_q;
    op_t                   op_q;

    logic                  req;
    op_t                   op_in;
    logic [DEPTH_W-1:0]    idx_in;
    op_t                   cur_op;
    logic [DEPTH_W-1:0]    cur_idx;
    logic [DATA_W-1:0]     cur_wdata;
    logic                  enter_resp;
    logic                  ram_we, ram_re;
    logic                  unused_addr;

    assign req         = cache2mem_MemWrite | cache2mem_MemRead;
    assign op_in       = cache2mem_MemWrite ? OP_WRITE : OP_READ;
    assign idx_in      = cache2mem_addr[DEPTH_W+1:2];
    assign unused_addr = ^cache2mem_addr;

    // With LATENCY==1 the commit edge is the acceptance edge, so the RAM
    // must see the live request in IDLE rather than the latched copy.
    assign cur_op    = (state == S_IDLE) ? op_in          : op_q;
    assign cur_idx   = (state == S_IDLE) ? idx_in         : idx_q;
    assign cur_wdata = (state == S_IDLE) ? cache2mem_data : wdata_q;

    // Gated by iRST_n so an abandoned transaction never writes the array.
    assign enter_resp = iRST_n && (next_state == S_RESP);
    assign ram_we     = enter_resp && (cur_op == OP_WRITE);
    assign ram_re     = enter_resp && (cur_op == OP_READ);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        next_state      = state;
        cnt_d           = cnt;
        mem2cache_ready = 1'b0;
        mem_busy        = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        next_state = S_RESP;
                    end else begin
                        next_state = S_BUSY;
                        cnt_d      = LAT_CNT_W'(LATENCY - 2);
                    end
                end
            end
            S_BUSY: begin
                mem_busy = 1'b1;
                if (cnt == '0) next_state = S_RESP;
                else           cnt_d      = cnt - LAT_CNT_W'(1);
            end
            S_RESP: begin
                mem_busy        = 1'b1;
                mem2cache_ready = 1'b1;
                next_state      = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            idx_q   <= '0;
            wdata_q <= '0;
            op_q    <= OP_READ;
        end else if (state == S_IDLE && req) begin
            idx_q   <= idx_in;
            wdata_q <= cache2mem_data;
            op_q    <= op_in;
        end
    end

    main_mem_array #(
        .DEPTH_W (DEPTH_W),
        .DATA_W  (DATA_W)
    ) u_array (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .we     (ram_we),
        .re     (ram_re),
        .addr   (cur_idx),
        .wdata  (cur_wdata),
        .rdata  (mem2cache_data)
    );

`ifdef MAIN_MEM_STATS_EN
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (ram_re) rd_count <= rd_count + 32'd1;
            if (ram_we) wr_count <= wr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_main_mem_controller.sv
// Directed bench: instance A at LATENCY=4, instance B at LATENCY=1.
module tb_main_mem_controller;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_wr, a_rd, a_ready, a_busy;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_wr, b_rd, b_ready, b_busy;
`ifdef MAIN_MEM_STATS_EN
    logic [31:0] a_rdc, a_wrc, b_rdc, b_wrc;
    logic [31:0] rdc0, wrc0;
`endif

    int checks = 0;
    int errors = 0;
    int lat;
    logic [31:0] exp_d;

    always #5 clk = ~clk;

    main_mem_controller #(.ADDR_W(32), .DATA_W(32), .DEPTH_W(10), .LATENCY(4)) dut_a (
        .iCLK               (clk),
        .iRST_n             (rst_n),
        .cache2mem_addr     (a_addr),
        .cache2mem_data     (a_wdata),
        .cache2mem_MemWrite (a_wr),
        .cache2mem_MemRead  (a_rd),
        .mem2cache_data     (a_rdata),
        .mem2cache_ready    (a_ready),
        .mem_busy           (a_busy)
`ifdef MAIN_MEM_STATS_EN
        ,
        .rd_count           (a_rdc),
        .wr_count           (a_wrc)
`endif
    );

    main_mem_controller #(.ADDR_W(32), .DATA_W(32), .DEPTH_W(10), .LATENCY(1)) dut_b (
        .iCLK               (clk),
        .iRST_n             (rst_n),
        .cache2mem_addr     (b_addr),
        .cache2mem_data     (b_wdata),
        .cache2mem_MemWrite (b_wr),
        .cache2mem_MemRead  (b_rd),
        .mem2cache_data     (b_rdata),
        .mem2cache_ready    (b_ready),
        .mem_busy           (b_busy)
`ifdef MAIN_MEM_STATS_EN
        ,
        .rd_count           (b_rdc),
        .wr_count           (b_wrc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ready_of(input int d);
        return (d == 0) ? a_ready : b_ready;
    endfunction

    task automatic clear_req(input int d);
        if (d == 0) begin a_wr = 1'b0; a_rd = 1'b0; end
        else        begin b_wr = 1'b0; b_rd = 1'b0; end
    endtask

    // Called at a negedge; returns at the negedge where ready is seen, with
    // the request already dropped so a follow-up can be driven immediately.
    task automatic txn(input int d, input logic wr, input logic rd,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic hold, output int n);
        if (d == 0) begin a_wr = wr; a_rd = rd; a_addr = addr; a_wdata = wdata; end
        else        begin b_wr = wr; b_rd = rd; b_addr = addr; b_wdata = wdata; end
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!hold && n == 1) clear_req(d);
        end while (!ready_of(d) && n < 40);
        clear_req(d);
    endtask

    initial begin
        rst_n = 1'b0;
        a_wr = 1'b0; a_rd = 1'b0; a_addr = '0; a_wdata = '0;
        b_wr = 1'b0; b_rd = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_busy",  {31'd0, a_busy},  32'd0);
        chk("rst_data",  a_rdata,          32'd0);
`ifdef MAIN_MEM_STATS_EN
        chk("rst_rdc", a_rdc, 32'd0);
        chk("rst_wrc", a_wrc, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Read after write, LATENCY=4
        txn(0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 1'b1, lat);
        chk("wr40_lat", lat, 32'd4);
        @(negedge clk);
        chk("ready_one_cycle", {31'd0, a_ready}, 32'd0);
        chk("idle_not_busy",   {31'd0, a_busy},  32'd0);
        txn(0, 1'b0, 1'b1, 32'h40, 32'h0, 1'b1, lat);
        chk("rd40_lat",  lat,     32'd4);
        chk("rd40_data", a_rdata, 32'hDEADBEEF);
        @(negedge clk);

        // Write-back then allocate, read issued in the ready cycle
        txn(0, 1'b1, 1'b0, 32'h04, 32'h0BADF00D, 1'b1, lat);
        @(negedge clk);
        txn(0, 1'b1, 1'b0, 32'h84, 32'h11111111, 1'b1, lat);
        chk("wb84_lat", lat, 32'd4);
        txn(0, 1'b0, 1'b1, 32'h04, 32'h0, 1'b1, lat);
        chk("alloc_lat",  lat,     32'd5);
        chk("alloc_data", a_rdata, 32'h0BADF00D);
        @(negedge clk);
        txn(0, 1'b0, 1'b1, 32'h84, 32'h0, 1'b1, lat);
        chk("rd84_data", a_rdata, 32'h11111111);
        @(negedge clk);

        // Aliasing: 0x1000 and 0x0002 both map to word 0
        txn(0, 1'b1, 1'b0, 32'h1000, 32'hA5A5A5A5, 1'b1, lat);
        @(negedge clk);
        txn(0, 1'b0, 1'b1, 32'h0002, 32'h0, 1'b1, lat);
        chk("alias_data", a_rdata, 32'hA5A5A5A5);
        @(negedge clk);

        // Combined read+write counts as a write only
`ifdef MAIN_MEM_STATS_EN
        rdc0 = a_rdc; wrc0 = a_wrc;
`endif
        txn(0, 1'b1, 1'b1, 32'h08, 32'h12345678, 1'b1, lat);
        chk("comb_lat",  lat,     32'd4);
        chk("comb_hold", a_rdata, 32'hA5A5A5A5);
`ifdef MAIN_MEM_STATS_EN
        chk("comb_wrc", a_wrc, wrc0 + 32'd1);
        chk("comb_rdc", a_rdc, rdc0);
`endif
        @(negedge clk);
        txn(0, 1'b0, 1'b1, 32'h08, 32'h0, 1'b1, lat);
        chk("comb_mem", a_rdata, 32'h12345678);
        @(negedge clk);

        // Request dropped after acceptance still completes
        txn(0, 1'b1, 1'b0, 32'h20, 32'h00000077, 1'b0, lat);
        chk("drop_lat", lat, 32'd4);
        @(negedge clk);
        txn(0, 1'b0, 1'b1, 32'h20, 32'h0, 1'b1, lat);
        chk("drop_data", a_rdata, 32'h00000077);
        @(negedge clk);

        // Reset in the cycle before RESP abandons the write
        txn(0, 1'b1, 1'b0, 32'h10, 32'h55AA55AA, 1'b1, lat);
        @(negedge clk);
        a_wr = 1'b1; a_addr = 32'h10; a_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        chk("busy_in_busy", {31'd0, a_busy}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_ready", {31'd0, a_ready}, 32'd0);
        chk("rstmid_busy",  {31'd0, a_busy},  32'd0);
        chk("rstmid_data",  a_rdata,          32'd0);
        a_wr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b1, lat);
        chk("rstmid_old", a_rdata, 32'h55AA55AA);
        @(negedge clk);

        // LATENCY=1 sweep, back-to-back write/read pairs
        for (int i = 0; i < 8; i++) begin
            exp_d = 32'hC0DE0000 + 32'(i * 17);
            txn(1, 1'b1, 1'b0, 32'(4 * i), exp_d, 1'b1, lat);
            chk($sformatf("sw_wlat%0d", i), lat, (i == 0) ? 32'd1 : 32'd2);
            txn(1, 1'b0, 1'b1, 32'(4 * i), 32'h0, 1'b1, lat);
            chk($sformatf("sw_rlat%0d", i), lat,     32'd2);
            chk($sformatf("sw_data%0d", i), b_rdata, exp_d);
        end
        @(negedge clk);
        chk("sw_ready_drop", {31'd0, b_ready}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/main_mem_controller.md
Name: main_mem_controller

Overview:
Memory-side responder for the cache-to-RAM request interface. It accepts level-held MemRead/MemWrite requests from the cache controller, applies a fixed, parameterised access latency, and then commits writes to or returns reads from an internal word-addressed RAM array. Completion is signalled with a single-cycle ready pulse. It sits between the cache controller and the backing store and stands in for main memory in the FPGA build.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, data word width
DEPTH_W, 10, log2 of array depth in words (1024 words)
LATENCY, 4, cycles from request acceptance to ready pulse; legal range 1..15

Ports:
iCLK  in  1  clock, rising edge
iRST_n  in  1  reset, asynchronous, active-low
cache2mem_addr  in  ADDR_W  byte address of the request
cache2mem_data  in  DATA_W  write data
cache2mem_MemWrite  in  1  write request, held until ready
cache2mem_MemRead  in  1  read request, held until ready
mem2cache_data  out  DATA_W  read data, valid while mem2cache_ready=1 and held afterwards
mem2cache_ready  out  1  one-cycle completion pulse
mem_busy  out  1  high in BUSY and RESP states

Behaviour:
- Reset: asynchronous, active-low on iRST_n; clock iCLK.
  - Reset values: state=IDLE, mem2cache_ready=0, mem2cache_data=0, mem_busy=0, counter=0.
  - Array contents are not reset.
- Word index = addr[DEPTH_W+1:2]. Bits [1:0] are ignored (word aligned). Bits above DEPTH_W+1 are ignored, so addresses alias modulo 4*2^DEPTH_W.
- State machine, 3 states:
  - IDLE: sample requests on each edge. If MemWrite or MemRead is high, latch addr, wdata and op (write takes priority when both are high). Then go to RESP if LATENCY==1, otherwise load counter=LATENCY-2 and go to BUSY.
  - BUSY: decrement counter. When counter==0, go to RESP. The request inputs are ignored in this state; the latched copy is authoritative.
  - RESP: mem2cache_ready=1 for exactly one cycle, then return to IDLE unconditionally.
- Commit and read timing: on the edge entering RESP:
  - a write stores the latched wdata at the latched index;
  - a read loads array[latched index] into mem2cache_data.
- mem2cache_data holds its value until the next read completes. Writes leave it unchanged.
- Latency: request seen at edge E0 gives ready high during the cycle after edge E0+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Handshake: the requester drops or changes its request in the same cycle that ready is high. A request present at the edge leaving RESP is therefore not accepted. It is sampled at the next edge in IDLE. This is one idle cycle minimum between transactions.
- Back-to-back: the write-back-then-allocate sequence (MemWrite completes, MemRead with a new address asserted the same cycle) is accepted at the first IDLE edge.
- Both MemRead and MemWrite high: treated as a write only, and the read is not performed.
- Request deasserted mid-BUSY: the transaction still completes and ready still pulses.
- Reset mid-operation: the transaction is abandoned and no array write occurs, even if reset asserts in the cycle before RESP.

Optional Feature:
MAIN_MEM_STATS_EN
- Defined: adds outputs rd_count[31:0] and wr_count[31:0].
  - Each increments by 1 on the edge entering RESP for its op type, and wraps at 2^32.
  - Both reset to 0.
  - A combined read+write request counts as a write only.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package main_mem_pkg:
  - state encoding constants S_IDLE=2'd0, S_BUSY=2'd1, S_RESP=2'd2;
  - OP_READ/OP_WRITE constants;
  - latency-counter width LAT_CNT_W=4.
- One sub-module, main_mem_array: single-port synchronous write / synchronous read word RAM (DEPTH_W, DATA_W), inferable as FPGA block RAM.
- The FSM, latches and counter stay in the top module.

Test Plan:
- Read after write: LATENCY=4, write 0xDEADBEEF to 0x40, then read 0x40.
  - Ready pulses 4 cycles after each acceptance.
  - The read returns 0xDEADBEEF.
  - Ready is high for exactly 1 cycle.
- Write-back then allocate: write 0x11111111 to 0x84 with MemRead to 0x04 asserted in the ready cycle.
  - The read is accepted next edge and returns the prior contents of 0x04.
  - 0x84 holds 0x11111111.
- Aliasing and alignment, DEPTH_W=10: write 0xA5A5A5A5 to 0x1000, then read 0x0002.
  - Returns 0xA5A5A5A5 (index 0, low bits ignored).
- Combined request: MemRead=MemWrite=1, addr 0x08, data 0x12345678.
  - Array[2]=0x12345678.
  - mem2cache_data is unchanged from the previous read.
  - wr_count+1, rd_count+0 when MAIN_MEM_STATS_EN is defined.
- Reset mid-BUSY: issue a write of 0xFFFFFFFF to 0x10, assert iRST_n=0 two cycles after acceptance.
  - Ready, busy and data go to 0 immediately.
  - A later read of 0x10 returns the old value.
- LATENCY=1 sweep: 16 alternating writes and reads to consecutive addresses.
  - Ready arrives 1 cycle after each acceptance, with exactly one idle cycle between transactions.
  - All read data matches.
